// File: rtl/pitch_glide_ctrl_if.sv
// Request channel from the user-interface logic into pitch_glide_ctrl.
//   req_valid  : request present (master -> slave)
//   req_ready  : request accepted when high together with req_valid (slave -> master)
//   req_ratio  : requested ratio, 8.8 unsigned (master -> slave)
//   req_bypass : 1 = return to bypass, req_ratio ignored (master -> slave)
interface pitch_glide_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_ratio;
  logic        req_bypass;

  modport master (output req_valid, output req_ratio, output req_bypass, input req_ready);
  modport slave  (input req_valid, input req_ratio, input req_bypass, output req_ready);
endinterface

// File: rtl/pitch_glide_ctrl.sv
// Control-plane sequencer for the pitch shifter datapath. Owns the datapath
// enable and pitch_ratio, warms the delay buffer before engaging, and glides
// the ratio toward each new target by at most STEP per sample tick. enable is
// only dropped once the ratio is back at unity, so bypass is click-free.
// Ports:
//   CLOCK_50    : system clock, rising edge
//   reset       : synchronous active-high reset
//   tick        : one-cycle sample strobe shared with the datapath
//   req         : request channel (valid/ready, ratio, bypass)
//   pitch_ratio : ratio to datapath, 8.8 unsigned (registered)
//   enable      : datapath enable (registered)
//   busy        : high in WARMUP, GLIDE or RELEASE (registered)
//   state_dbg   : BYPASS=0 WARMUP=1 GLIDE=2 ACTIVE=3 RELEASE=4
module pitch_glide_ctrl #(
  parameter logic [15:0] UNITY     = 16'h0100,
  parameter logic [15:0] STEP      = 16'd1,
  parameter logic [15:0] WARMUP    = 16'd2048,
  parameter logic [15:0] RATIO_MIN = 16'h0080,
  parameter logic [15:0] RATIO_MAX = 16'h0200
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick,
  pitch_glide_ctrl_if.slave req,
  output logic [15:0]       pitch_ratio,
  output logic              enable,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam int unsigned RW = 16;
  localparam int unsigned DW = RW + 1;

  typedef enum logic [2:0] {
    S_BYPASS  = 3'd0,
    S_WARMUP  = 3'd1,
    S_GLIDE   = 3'd2,
    S_ACTIVE  = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   ratio_q, ratio_d;
  logic [RW-1:0]   target_q, target_d;
  logic [RW-1:0]   warm_q, warm_d;
  logic            enable_q, enable_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            accept_c;
  logic [RW-1:0]   clamped_c;
  logic signed [DW-1:0] diff_c;
  logic signed [DW-1:0] step_s_c;
  logic            reached_c;
  logic [RW-1:0]   stepped_c;

  // Handshake and clamp of the incoming ratio.
  assign accept_c  = req.req_valid && ready_q;
  assign clamped_c = (req.req_ratio < RATIO_MIN) ? RATIO_MIN :
                     (req.req_ratio > RATIO_MAX) ? RATIO_MAX : req.req_ratio;

  // Glide arithmetic: 17-bit signed difference so no wrap around 0/0xFFFF.
  assign diff_c    = $signed({1'b0, target_q}) - $signed({1'b0, ratio_q});
  assign step_s_c  = $signed({1'b0, STEP});
  assign reached_c = (diff_c <= step_s_c) && (diff_c >= -step_s_c);
  assign stepped_c = diff_c[DW-1] ? RW'(ratio_q - STEP) : RW'(ratio_q + STEP);

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    target_d = target_q;
    warm_d   = warm_q;
    enable_d = enable_q;

    case (state_q)
      S_BYPASS: begin
        enable_d = 1'b0;
        ratio_d  = UNITY;
        if (accept_c && !req.req_bypass) begin
          target_d = clamped_c;
          warm_d   = '0;
          state_d  = S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (tick) begin
          warm_d = RW'(warm_q + 16'd1);
          if (warm_q == RW'(WARMUP - 16'd1)) begin
            enable_d = 1'b1;
            state_d  = (target_q == UNITY) ? S_ACTIVE : S_GLIDE;
          end
        end
      end
      S_GLIDE: begin
        if (tick) begin
          if (reached_c) begin
            ratio_d = target_q;
            state_d = S_ACTIVE;
          end else begin
            ratio_d = stepped_c;
          end
        end
      end
      S_ACTIVE: begin
        // A request on a tick edge only changes state; stepping starts next tick.
        if (accept_c) begin
          if (req.req_bypass) begin
            target_d = UNITY;
            state_d  = S_RELEASE;
          end else begin
            target_d = clamped_c;
            state_d  = (clamped_c == ratio_q) ? S_ACTIVE : S_GLIDE;
          end
        end
      end
      S_RELEASE: begin
        if (tick) begin
          if (reached_c) begin
            ratio_d  = target_q;
            enable_d = 1'b0;
            state_d  = S_BYPASS;
          end else begin
            ratio_d = stepped_c;
          end
        end
      end
      default: begin
        state_d  = S_BYPASS;
        ratio_d  = UNITY;
        target_d = UNITY;
        enable_d = 1'b0;
      end
    endcase

    // Ready and busy follow the state being entered.
    ready_d = (state_d == S_BYPASS) || (state_d == S_ACTIVE);
    busy_d  = (state_d == S_WARMUP) || (state_d == S_GLIDE) || (state_d == S_RELEASE);
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_BYPASS;
      ratio_q  <= UNITY;
      target_q <= UNITY;
      warm_q   <= '0;
      enable_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      target_q <= target_d;
      warm_q   <= warm_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign req.req_ready = ready_q;
  assign pitch_ratio   = ratio_q;
  assign enable        = enable_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pitch_glide_ctrl.sv
// Bench for pitch_glide_ctrl: two instances (STEP=1 and STEP=3, WARMUP=16)
// share one stimulus stream; a reference model per instance predicts the
// outputs after every edge into a queue, and a monitor pops and compares.
module tb_pitch_glide_ctrl;

  localparam int UNI  = 'h0100;
  localparam int RMIN = 'h0080;
  localparam int RMAX = 'h0200;
  localparam int WARM = 16;

  logic CLOCK_50 = 1'b0;
  logic reset;
  logic tick;

  always #5 CLOCK_50 = ~CLOCK_50;

  pitch_glide_ctrl_if req_a ();
  pitch_glide_ctrl_if req_b ();

  logic [15:0] ratio_a, ratio_b;
  logic        en_a, en_b, busy_a, busy_b;
  logic [2:0]  dbg_a, dbg_b;

  pitch_glide_ctrl #(
    .UNITY(16'h0100), .STEP(16'd1), .WARMUP(16'd16),
    .RATIO_MIN(16'h0080), .RATIO_MAX(16'h0200)
  ) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .req(req_a),
    .pitch_ratio(ratio_a), .enable(en_a), .busy(busy_a), .state_dbg(dbg_a)
  );

  pitch_glide_ctrl #(
    .UNITY(16'h0100), .STEP(16'd3), .WARMUP(16'd16),
    .RATIO_MIN(16'h0080), .RATIO_MAX(16'h0200)
  ) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .req(req_b),
    .pitch_ratio(ratio_b), .enable(en_b), .busy(busy_b), .state_dbg(dbg_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0=bypass 1=warmup 2=glide 3=active 4=release.
  int m_mode[2];
  int m_ratio[2];
  int m_tgt[2];
  int m_ticks[2];
  bit m_en[2];
  int m_step[2] = '{1, 3};

  logic [21:0] exp_q0[$];
  logic [21:0] exp_q1[$];

  function automatic bit m_ready(int k);
    return (m_mode[k] == 0) || (m_mode[k] == 3);
  endfunction

  function automatic logic [21:0] exp_vec(int k);
    logic bz;
    bz = (m_mode[k] == 1) || (m_mode[k] == 2) || (m_mode[k] == 4);
    return {3'(m_mode[k]), 16'(m_ratio[k]), m_en[k], m_ready(k), bz};
  endfunction

  task automatic model_edge(int k, bit rst, bit tk, bit v, int r, bit byp);
    bit acc;
    int want;
    int d;
    acc  = v && m_ready(k);
    want = (r < RMIN) ? RMIN : ((r > RMAX) ? RMAX : r);
    if (rst) begin
      m_mode[k] = 0; m_ratio[k] = UNI; m_tgt[k] = UNI; m_ticks[k] = 0; m_en[k] = 0;
      return;
    end
    case (m_mode[k])
      0: if (acc && !byp) begin m_tgt[k] = want; m_ticks[k] = 0; m_mode[k] = 1; end
      1: if (tk) begin
           m_ticks[k] = m_ticks[k] + 1;
           if (m_ticks[k] == WARM) begin
             m_en[k] = 1;
             m_mode[k] = (m_tgt[k] == UNI) ? 3 : 2;
           end
         end
      2, 4: if (tk) begin
           d = m_tgt[k] - m_ratio[k];
           if (d <= m_step[k] && d >= -m_step[k]) begin
             m_ratio[k] = m_tgt[k];
             if (m_mode[k] == 4) begin m_en[k] = 0; m_mode[k] = 0; end
             else m_mode[k] = 3;
           end else begin
             m_ratio[k] = m_ratio[k] + ((d > 0) ? m_step[k] : -m_step[k]);
           end
         end
      3: if (acc) begin
           if (byp) begin m_tgt[k] = UNI; m_mode[k] = 4; end
           else begin m_tgt[k] = want; m_mode[k] = (want == m_ratio[k]) ? 3 : 2; end
         end
      default: ;
    endcase
  endtask

  // Drive one edge's inputs, advance the models, queue expected outputs.
  task automatic drive_cycle(bit rst, bit tk, bit v, int r, bit byp);
    @(negedge CLOCK_50);
    reset = rst; tick = tk;
    req_a.req_valid = v; req_a.req_ratio = 16'(r); req_a.req_bypass = byp;
    req_b.req_valid = v; req_b.req_ratio = 16'(r); req_b.req_bypass = byp;
    model_edge(0, rst, tk, v, r, byp);
    model_edge(1, rst, tk, v, r, byp);
    exp_q0.push_back(exp_vec(0));
    exp_q1.push_back(exp_vec(1));
  endtask

  // Monitor: compare every registered output set against the queue.
  always @(posedge CLOCK_50) begin
    logic [21:0] e, g;
    #1;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      g = {dbg_a, ratio_a, en_a, req_a.req_ready, busy_a};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL out_a t=%0t got st=%0d ratio=%h en=%b rdy=%b busy=%b exp st=%0d ratio=%h en=%b rdy=%b busy=%b",
                 $time, g[21:19], g[18:3], g[2], g[1], g[0], e[21:19], e[18:3], e[2], e[1], e[0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      g = {dbg_b, ratio_b, en_b, req_b.req_ready, busy_b};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL out_b t=%0t got st=%0d ratio=%h en=%b rdy=%b busy=%b exp st=%0d ratio=%h en=%b rdy=%b busy=%b",
                 $time, g[21:19], g[18:3], g[2], g[1], g[0], e[21:19], e[18:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic idle(int n, int tick_pct);
    for (int i = 0; i < n; i++)
      drive_cycle(0, ($urandom_range(0, 99) < tick_pct), 0, 0, 0);
  endtask

  // Run idle cycles with random ticks until both models are in BYPASS/ACTIVE.
  task automatic settle(string name, int limit);
    int n;
    n = 0;
    while (!(m_ready(0) && m_ready(1))) begin
      drive_cycle(0, ($urandom_range(0, 99) < 40), 0, 0, 0);
      n++;
      if (n > limit) begin
        checks++; failures++;
        $display("FAIL settle_%s timeout after %0d cycles modes=%0d/%0d", name, n, m_mode[0], m_mode[1]);
        return;
      end
    end
  endtask

  task automatic request(int r, bit byp);
    drive_cycle(0, $urandom_range(0, 1), 1, r, byp);
  endtask

  // Fixed-value spot check of both instances just after the next edge.
  task automatic expect_dut(string name, int ra, int rb, int st, bit en);
    @(posedge CLOCK_50);
    #2;
    checks++;
    if (ratio_a !== 16'(ra) || ratio_b !== 16'(rb) || dbg_a !== 3'(st) || dbg_b !== 3'(st)
        || en_a !== en || en_b !== en) begin
      failures++;
      $display("FAIL spot_%s got a=%h/%0d/%b b=%h/%0d/%b exp a=%h b=%h st=%0d en=%b",
               name, ratio_a, dbg_a, en_a, ratio_b, dbg_b, en_b, ra, rb, st, en);
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; tick = 1'b0;
    req_a.req_valid = 1'b0; req_a.req_ratio = '0; req_a.req_bypass = 1'b0;
    req_b.req_valid = 1'b0; req_b.req_ratio = '0; req_b.req_bypass = 1'b0;

    // Reset during random activity.
    for (int i = 0; i < 2; i++)
      drive_cycle(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    expect_dut("reset", UNI, UNI, 0, 0);

    // Engage, warm up, glide to 0x0110.
    request('h0110, 0);
    settle("engage", 3000);
    expect_dut("engage", 'h0110, 'h0110, 3, 1);

    // Clamp high and low.
    request('h0400, 0);
    settle("clamp_hi", 3000);
    expect_dut("clamp_hi", 'h0200, 'h0200, 3, 1);
    request('h0010, 0);
    settle("clamp_lo", 3000);
    expect_dut("clamp_lo", 'h0080, 'h0080, 3, 1);

    // Step-3 approach from 0x0110 to 0x0108.
    request('h0110, 0);
    settle("to_110", 3000);
    request('h0108, 0);
    settle("to_108", 3000);
    expect_dut("to_108", 'h0108, 'h0108, 3, 1);

    // Release from 0x0102.
    request('h0102, 0);
    settle("to_102", 3000);
    request(0, 1);
    settle("release", 3000);
    expect_dut("release", UNI, UNI, 0, 0);

    // Valid held while busy is ignored; target stays 0x0180.
    request('h0180, 0);
    for (int i = 0; i < 20; i++) drive_cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive_cycle(0, 1, 1, 'h01F0, 0);
    settle("hold", 3000);
    expect_dut("hold", 'h0180, 'h0180, 3, 1);

    // Reset mid-warmup after 7 ticks.
    request(0, 1);
    settle("rel2", 3000);
    request('h0150, 0);
    for (int i = 0; i < 7; i++) drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(1, 1, 1, 'h0150, 0);
    expect_dut("mid_warm_rst", UNI, UNI, 0, 0);
    idle(10, 50);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0: r = int'($urandom_range(0, 65535));
        1: r = int'($urandom_range(RMIN - 8, RMAX + 8));
        2: r = UNI;
        default: r = m_ratio[0] + int'($urandom_range(0, 8)) - 4;
      endcase
      drive_cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 99) < 60),
                  ($urandom_range(0, 99) < 15), r, ($urandom_range(0, 3) == 0));
    end

    @(posedge CLOCK_50);
    #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pitch_glide_ctrl.md
Name: pitch_glide_ctrl

Overview:
- Control-plane sequencer for the pitch shifter datapath.
- Owns that datapath's `enable` and `pitch_ratio` inputs.
- Accepts ratio/bypass requests from the user-interface logic through a valid/ready handshake.
- Warms the delay buffer before engaging, then glides `pitch_ratio` toward a new target in sample-rate steps to avoid zipper noise. It only drops `enable` once the ratio is back at unity, so bypass transitions are click-free.

Parameters:
- UNITY, 16'h0100: unity ratio in 8.8 fixed point; this is also the reset and bypass ratio.
- STEP, 16'd1: maximum ratio change per tick (8.8 units).
- WARMUP, 16'd2048: ticks counted after an engage request before `enable` is asserted, so the buffer fills.
- RATIO_MIN, 16'h0080: lower clamp for requested ratios (0.5x).
- RATIO_MAX, 16'h0200: upper clamp for requested ratios (2.0x).

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle sample strobe, shared with the datapath.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_ratio  in  16  requested ratio, 8.8 unsigned.
- req_bypass  in  1  1 = return to bypass; req_ratio is ignored.
- pitch_ratio  out  16  ratio driven to the datapath, 8.8 unsigned.
- enable  out  1  datapath enable.
- busy  out  1  high in WARMUP, GLIDE or RELEASE.
- state_dbg  out  3  state code: BYPASS=0, WARMUP=1, GLIDE=2, ACTIVE=3, RELEASE=4.

Behaviour:
- All outputs are registered.
- Reset:
  - Dominates tick and requests.
  - Next edge gives state BYPASS, pitch_ratio=UNITY, enable=0, req_ready=1, busy=0, target=UNITY, warm_cnt=0.
  - Reset in any state, including mid-WARMUP or mid-glide, returns to these values in one cycle.
- Handshake:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready=1 only in BYPASS and ACTIVE, and is 0 in every other state.
  - req_ready is recomputed from the next state, so it drops the cycle after an accept that leaves BYPASS or ACTIVE.
  - While req_ready=0, req_valid is ignored; nothing is queued.
- Clamp: an accepted ratio becomes target = min(max(req_ratio, RATIO_MIN), RATIO_MAX).
- BYPASS:
  - enable=0, pitch_ratio=UNITY.
  - Accept with req_bypass=1: no-op.
  - Accept with req_bypass=0: latch target, clear warm_cnt, go to WARMUP.
- WARMUP:
  - enable=0; pitch_ratio stays UNITY.
  - warm_cnt increments on each tick.
  - On the tick where warm_cnt == WARMUP-1:
    - enable=1 at that edge.
    - Next state is ACTIVE if target == UNITY, else GLIDE.
- GLIDE:
  - enable=1; pitch_ratio updates only on tick edges.
  - If |target − pitch_ratio| <= STEP: pitch_ratio <= target and go to ACTIVE.
  - Otherwise pitch_ratio moves by STEP toward target.
  - The difference is computed in 17-bit signed arithmetic, so there is no wrap.
- ACTIVE:
  - enable=1; pitch_ratio holds.
  - Accept with req_bypass=0: latch the clamped target. Go to GLIDE, or stay in ACTIVE if it equals pitch_ratio.
  - Accept with req_bypass=1: target=UNITY, go to RELEASE.
- RELEASE:
  - Same glide rule toward UNITY.
  - On the tick where pitch_ratio reaches UNITY, enable <= 0 on that same edge and go to BYPASS.
  - If RELEASE is entered with pitch_ratio already at UNITY, this happens on the first tick.
- Invariants:
  - pitch_ratio never changes on a non-tick cycle (reset excepted).
  - enable falls only with pitch_ratio == UNITY.
  - pitch_ratio stays within [min(UNITY, RATIO_MIN), max(UNITY, RATIO_MAX)].
- Simultaneous events: a request and a tick on the same edge in ACTIVE or BYPASS cause the state transition only. The first step toward the new target occurs on the next tick.
- The design is sized for roughly 150–250 lines of RTL.

Test Plan:
1. Assert reset for 2 cycles during random tick/req activity -> pitch_ratio=0x0100, enable=0, req_ready=1, state_dbg=0, busy=0.
2. Engage with WARMUP=16, STEP=1, req_ratio=0x0110 -> req_ready drops, state_dbg=1. enable rises at the 16th tick, then pitch_ratio steps 0x0101..0x0110 over 16 ticks, state_dbg=3, busy=0.
3. Clamp: in ACTIVE, request 0x0400 -> target 0x0200 and glide terminates at exactly 0x0200. Request 0x0010 -> terminates at 0x0080.
4. With STEP=3, ACTIVE at 0x0110, request 0x0108 -> successive tick values 0x010D, 0x010A, 0x0108, then ACTIVE. Idle cycles between ticks show no change.
5. Release: ACTIVE at 0x0102 with STEP=1, send req_bypass=1 -> 0x0101, then 0x0100 with enable=0 on the same edge, state_dbg=0, req_ready=1.
6. Hold req_valid during GLIDE -> no accept and target unchanged. Then assert reset mid-WARMUP (warm_cnt=7) -> BYPASS next cycle and enable never rose.
